voice_sequencer: RTL

//   Per-sample scheduler for the shared, time-multiplexed voice generator (multi_voice).
//   On each sample tick it snapshots all voice configs and drives start/act_voice/config for voices 0..N-1 in turn.
//   It captures each voice's wave, sums the enabled voices into a signed mix and emits one mix sample per tick.

---
 rtl/tt6581_pkg.sv | 21 ++
 rtl/voice_sequencer.sv | 132 +++++++++++++
 2 files changed

// File: rtl/tt6581_pkg.sv
// Shared definitions for the tt6581 voice path.
//   NUM_VOICES / WAVE_W / MIX_W : voice count and datapath widths
//   WAVE_*                      : one-hot waveform select codes
//   seq_state_e                 : voice_sequencer FSM states
package tt6581_pkg;
   localparam int NUM_VOICES = 3;
   localparam int WAVE_W     = 10;
   localparam int MIX_W      = 12;

   localparam logic [3:0] WAVE_TRI   = 4'b0001;
   localparam logic [3:0] WAVE_SAW   = 4'b0010;
   localparam logic [3:0] WAVE_PULSE = 4'b0100;
   localparam logic [3:0] WAVE_NOISE = 4'b1000;

   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, WAIT} seq_state_e;

   // Sign-extend one generator sample to mix width.
   function automatic logic signed [MIX_W-1:0] sext_wave(input logic signed [WAVE_W-1:0] w);
      return {{(MIX_W-WAVE_W){w[WAVE_W-1]}}, w};
   endfunction
endpackage

// File: rtl/voice_sequencer.sv
// voice_sequencer: per-sample scheduler for the time-multiplexed voice generator.
// On tick_i it snapshots every voice config, runs voices 0..N-1 through the
// generator one at a time, sums the enabled waves and emits one mix per tick.
// Ports:
//   clk_i, rst_i (sync, active-high), tick_i      : clock, reset, sample strobe
//   freq_words_i / pw_words_i / wave_sels_i        : per-voice config inputs
//   voice_en_i                                     : per-voice mix enable
//   start_o, act_voice_o, freq_word_o, pw_word_o,
//   wave_sel_o                                     : request to generator
//   ready_i, wave_i                                : generator response
//   mix_o, mix_valid_o                             : summed sample + update pulse
//   busy_o, overrun_o, timeout_o                   : status (last two sticky)
module voice_sequencer
   import tt6581_pkg::*;
#(
   parameter int TIMEOUT = 8
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic                               tick_i,
   input  logic [NUM_VOICES-1:0][15:0]        freq_words_i,
   input  logic [NUM_VOICES-1:0][11:0]        pw_words_i,
   input  logic [NUM_VOICES-1:0][3:0]         wave_sels_i,
   input  logic [NUM_VOICES-1:0]              voice_en_i,
   output logic                               start_o,
   output logic [1:0]                         act_voice_o,
   output logic [15:0]                        freq_word_o,
   output logic [11:0]                        pw_word_o,
   output logic [3:0]                         wave_sel_o,
   input  logic                               ready_i,
   input  logic signed [WAVE_W-1:0]           wave_i,
   output logic signed [MIX_W-1:0]            mix_o,
   output logic                               mix_valid_o,
   output logic                               busy_o,
   output logic                               overrun_o,
   output logic                               timeout_o
);
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   seq_state_e                        state_q, state_d;
   logic [NUM_VOICES-1:0][15:0]       freq_sh;
   logic [NUM_VOICES-1:0][11:0]       pw_sh;
   logic [NUM_VOICES-1:0][3:0]        sel_sh;
   logic [NUM_VOICES-1:0]             en_sh;
   logic [1:0]                        idx_q;
   logic [CNT_W-1:0]                  cnt_q;
   logic signed [MIX_W-1:0]           acc_q;
   logic                              last_voice;
   logic                              wait_expired;

   assign last_voice   = (idx_q == 2'(NUM_VOICES-1));
   assign wait_expired = (cnt_q == CNT_W'(TIMEOUT-1));

   // Generator request comes straight from the shadow copy, so it cannot
   // move while a voice is in flight even if the config inputs do.
   assign act_voice_o = idx_q;
   assign freq_word_o = freq_sh[idx_q];
   assign pw_word_o   = pw_sh[idx_q];
   assign wave_sel_o  = sel_sh[idx_q];
   assign start_o     = (state_q == ISSUE);
   assign busy_o      = (state_q != IDLE);

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (tick_i) state_d = ISSUE;
         ISSUE:   state_d = CAPTURE;
         CAPTURE: state_d = WAIT;
         WAIT: begin
            if (ready_i)           state_d = last_voice ? IDLE : ISSUE;
            else if (wait_expired) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         freq_sh     <= '0;
         pw_sh       <= '0;
         sel_sh      <= '0;
         en_sh       <= '0;
         idx_q       <= '0;
         cnt_q       <= '0;
         acc_q       <= '0;
         mix_o       <= '0;
         mix_valid_o <= 1'b0;
         overrun_o   <= 1'b0;
         timeout_o   <= 1'b0;
      end else begin
         mix_valid_o <= 1'b0;
         if (tick_i && state_q != IDLE) overrun_o <= 1'b1;
         case (state_q)
            IDLE: begin
               if (tick_i) begin
                  freq_sh <= freq_words_i;
                  pw_sh   <= pw_words_i;
                  sel_sh  <= wave_sels_i;
                  en_sh   <= voice_en_i;
                  idx_q   <= '0;
                  acc_q   <= '0;
               end
            end
            CAPTURE: begin
               // Muted voices are still run so their phase keeps advancing.
               if (en_sh[idx_q]) acc_q <= acc_q + sext_wave(wave_i);
               cnt_q <= '0;
            end
            WAIT: begin
               if (ready_i) begin
                  if (last_voice) begin
                     mix_o       <= acc_q;
                     mix_valid_o <= 1'b1;
                  end else begin
                     idx_q <= idx_q + 2'd1;
                  end
               end else if (wait_expired) begin
                  timeout_o <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end
endmodule
